seq_stage_sequencer: RTL

//  Multi-cycle stage sequencer for the Y86-64 SEQ datapath: steps fetch, decode, execute,

---
 rtl/seq_stage_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seq_stage_sequencer.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ datapath.
// Steps one stage per cycle via one-hot enables, owns cc_we, stat and the busy/retire counters.
module seq_stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             en_fetch,
    output logic             en_decode,
    output logic             en_execute,
    output logic             en_memory,
    output logic             en_writeback,
    output logic             en_pc,
    output logic             cc_we,
    output logic             busy,
    output logic [2:0]       stat,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_PCUPDATE,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        icode_q, icode_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instr_q, instr_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
    function automatic logic needs_mem(input logic [3:0] ic);
        case (ic)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        icode_d = icode_q;
        wait_d  = wait_q;
        stat_d  = stat_q;
        cycle_d = cycle_q;
        instr_d = instr_q;

        if (state_q != S_IDLE && state_q != S_STOP) begin
            cycle_d = sat_inc(cycle_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                icode_d = icode;
                if (imem_error) begin
                    state_d = S_STOP;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_STOP;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = S_STOP;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                if (needs_mem(icode_q)) begin
                    state_d = S_MEMORY;
                    wait_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // an address error outranks a completion reported in the same cycle
                if (dmem_error) begin
                    state_d = S_STOP;
                    stat_d  = STAT_ADR;
                end else if (mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_STOP;
                    stat_d  = STAT_ADR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: state_d = S_PCUPDATE;
            S_PCUPDATE: begin
                instr_d = sat_inc(instr_q);
                state_d = S_FETCH;
            end
            S_STOP:  state_d = S_STOP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            icode_q <= 4'h0;
            wait_q  <= '0;
            stat_q  <= STAT_AOK;
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            wait_q  <= wait_d;
            stat_q  <= stat_d;
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign en_fetch     = (state_q == S_FETCH);
    assign en_decode    = (state_q == S_DECODE);
    assign en_execute   = (state_q == S_EXECUTE);
    assign en_memory    = (state_q == S_MEMORY);
    assign en_writeback = (state_q == S_WRITEBACK);
    assign en_pc        = (state_q == S_PCUPDATE);
    assign cc_we        = (state_q == S_EXECUTE) && (icode_q == 4'h6);
    assign busy         = (state_q != S_IDLE) && (state_q != S_STOP);
    assign stat         = stat_q;
    assign cycle_count  = cycle_q;
    assign instr_count  = instr_q;

endmodule
